// File: rtl/timer_irq_ctrl.sv
// ============================================================================
// timer_irq_ctrl
// ----------------------------------------------------------------------------
// APB-programmable interrupt controller for timer interrupt sources.
// Rising edges on irq_i latch into a pending register. Unmasked pending
// sources raise irq_o. Software then claims the winning source through the
// CLAIM register and completes it by writing the same id back to CLAIM.
//
// Register map (paddr[3:2]):
//   0 PEND   - pending bits, write-1-to-clear (a new edge beats the clear)
//   1 MASK   - enable bits, 1 = source enabled
//   2 CLAIM  - read: claim winner (id+1), write: complete (id+1)
//   3 STATUS - [1:0] state, [13:8] active id+1 while in SERVICE
//
// Optional feature:
//   TIMER_IRQ_CTRL_RR_EN - when defined, the winner is chosen round-robin,
//                          starting after the last granted source. When
//                          undefined, the lowest-index source wins.
//
// Ports:
//   pclk, presetn          - clock, asynchronous active-low reset
//   psel, penable, pwrite  - APB control
//   paddr, pwdata          - APB address / write data
//   prdata                 - APB read data (0 outside a read access phase)
//   pready, pslverr        - tied to 1 / 0
//   irq_i                  - level interrupt inputs, IRQ_NUM wide
//   irq_o                  - registered interrupt request to the CPU
// ============================================================================
module timer_irq_ctrl #(
    parameter int IRQ_NUM = 4
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               irq_o
);

    localparam int ID_W = 5;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_CLAIM  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                irq_o_nxt;

    logic [IRQ_NUM-1:0]  irq_q;
    logic [IRQ_NUM-1:0]  pend;
    logic [IRQ_NUM-1:0]  pend_nxt;
    logic [IRQ_NUM-1:0]  mask;
    logic [IRQ_NUM-1:0]  mask_nxt;
    logic [IRQ_NUM-1:0]  irq_rise;
    logic [IRQ_NUM-1:0]  w1c_clr;
    logic [IRQ_NUM-1:0]  claim_clr;
    logic [IRQ_NUM-1:0]  active;
    logic [IRQ_NUM-1:0]  active_nxt;

    logic [ID_W-1:0]     active_id;
    logic [ID_W-1:0]     win_id;
    logic                win_found;

    logic                wr_acc;
    logic                rd_acc;
    logic                claim_rd;
    logic                claim_take;
    logic                complete_hit;

    logic                unused_bits;

    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    // Only paddr[3:2] and the low pwdata bits are decoded.
    assign unused_bits = ^{paddr, pwdata};

    assign wr_acc = psel & penable & pwrite;
    assign rd_acc = psel & penable & ~pwrite;

    assign claim_rd   = rd_acc && (paddr[3:2] == ADDR_CLAIM);
    assign claim_take = claim_rd && (state == ARMED);

    assign complete_hit = wr_acc && (paddr[3:2] == ADDR_CLAIM) &&
                          (pwdata[5:0] == ({1'b0, active_id} + 6'd1));

    assign irq_rise = irq_i & ~irq_q;
    assign w1c_clr  = (wr_acc && (paddr[3:2] == ADDR_PEND)) ? pwdata[IRQ_NUM-1:0] : '0;
    assign mask_nxt = (wr_acc && (paddr[3:2] == ADDR_MASK)) ? pwdata[IRQ_NUM-1:0] : mask;

    // The edge term is OR-ed in last so that a new edge beats a same-cycle clear.
    assign pend_nxt   = (pend & ~(w1c_clr | claim_clr)) | irq_rise;
    assign active     = pend & mask;
    assign active_nxt = pend_nxt & mask_nxt;

    // One-hot clear of the source being claimed.
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (claim_take && (win_id == ID_W'(i))) begin
                claim_clr[i] = 1'b1;
            end
        end
    end

`ifdef TIMER_IRQ_CTRL_RR_EN
    logic [ID_W-1:0]      last_grant;
    logic [2*IRQ_NUM-1:0] active_dbl;
    logic [IRQ_NUM-1:0]   active_rot;

    // Rotate the request vector so that bit 0 is the source just after
    // last_grant. A fixed-priority search over the rotated vector then
    // gives the round-robin order. Shifting by IRQ_NUM wraps to the identity.
    assign active_dbl = {active, active} >> ({1'b0, last_grant} + 6'd1);
    assign active_rot = active_dbl[IRQ_NUM-1:0];

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < IRQ_NUM; k++) begin
            if (!win_found && active_rot[k]) begin
                win_found = 1'b1;
                idx       = int'(last_grant) + 1 + k;
                if (idx >= IRQ_NUM) begin
                    idx = idx - IRQ_NUM;
                end
                win_id = ID_W'(idx);
            end
        end
    end

    // last_grant remembers the most recent claim, so the next search starts after it.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant <= ID_W'(IRQ_NUM - 1);
        end else if (claim_take) begin
            last_grant <= win_id;
        end
    end
`else
    // Fixed priority: the lowest-index enabled pending source wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (!win_found && active[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`endif

    // Input sampling, pending/mask registers and the claimed id.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_q     <= '0;
            pend      <= '0;
            mask      <= '0;
            active_id <= '0;
        end else begin
            irq_q <= irq_i;
            pend  <= pend_nxt;
            mask  <= mask_nxt;
            if (claim_take) begin
                active_id <= win_id;
            end
        end
    end

    // State register. irq_o is registered beside it, so it mirrors ARMED
    // without any combinational path from irq_i.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            irq_o <= 1'b0;
        end else begin
            state <= state_nxt;
            irq_o <= irq_o_nxt;
        end
    end

    // ARMED is left as soon as the post-edge PEND & MASK would be empty.
    // Every cycle spent in ARMED therefore has a valid winner for a claim.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|active) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (claim_rd) begin
                    state_nxt = SERVICE;
                end else if (active_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (complete_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode for the registered interrupt request.
    always_comb begin
        irq_o_nxt = (state_nxt == ARMED);
    end

    // Read mux. The output is zero outside a read access phase.
    always_comb begin
        prdata = '0;
        if (rd_acc) begin
            case (paddr[3:2])
                ADDR_PEND:   prdata[IRQ_NUM-1:0] = pend;
                ADDR_MASK:   prdata[IRQ_NUM-1:0] = mask;
                ADDR_CLAIM: begin
                    if (state == ARMED) begin
                        prdata[5:0] = {1'b0, win_id} + 6'd1;
                    end
                end
                ADDR_STATUS: begin
                    prdata[1:0] = state;
                    if (state == SERVICE) begin
                        prdata[13:8] = {1'b0, active_id} + 6'd1;
                    end
                end
                default: prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// ============================================================================
// tb_timer_irq_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for timer_irq_ctrl (IRQ_NUM = 4).
// The stimulus process pushes the expected read data and irq_o level for
// every APB read. The monitor pops one entry per read access phase and
// compares it with the DUT outputs. Define TIMER_IRQ_CTRL_RR_EN to build
// the bench and RTL for the round-robin arbitration variant.
// ============================================================================
module tb_timer_irq_ctrl;

    localparam int IRQ_NUM = 4;

    localparam logic [31:0] A_PEND   = 32'h0;
    localparam logic [31:0] A_MASK   = 32'h4;
    localparam logic [31:0] A_CLAIM  = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

`ifdef TIMER_IRQ_CTRL_RR_EN
    localparam logic [31:0] FIRST_CLAIM  = 32'd3;
    localparam logic [31:0] SECOND_CLAIM = 32'd1;
`else
    localparam logic [31:0] FIRST_CLAIM  = 32'd1;
    localparam logic [31:0] SECOND_CLAIM = 32'd3;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic               pclk;
    logic               presetn;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;
    logic [IRQ_NUM-1:0] irq_i;
    logic               irq_o;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;
    logic stim_done;

    timer_irq_ctrl #(.IRQ_NUM(IRQ_NUM)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq_i   (irq_i),
        .irq_o   (irq_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One APB transfer (setup + access). Callers start just after a rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic wr);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
    endtask

    // Queue the expected read result, then issue the read.
    task automatic checkOutput(input string name, input logic [31:0] addr,
                               input logic [31:0] exp_data, input logic exp_irq);
        exp_t e;
        e.name = name;
        e.data = exp_data;
        e.irq  = exp_irq;
        sb_q.push_back(e);
        applyStimulus(addr, 32'h0, 1'b0);
    endtask

    // Hold a level on irq_i for two edges, then drop it.
    task automatic pulseIrq(input logic [IRQ_NUM-1:0] v);
        irq_i = v;
        repeat (2) begin
            @(posedge pclk); #1;
        end
        irq_i = '0;
    endtask

    // Monitor: compares every read access phase against the scoreboard and
    // owns the counters and the summary line.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge pclk);
            if (psel && penable && !pwrite) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_read: prdata=0x%08h irq_o=%0b, no expectation queued",
                             prdata, irq_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (prdata !== mon_e.data || irq_o !== mon_e.irq) begin
                        errors++;
                        $display("[TB] FAIL %s: got prdata=0x%08h irq_o=%0b, expected prdata=0x%08h irq_o=%0b",
                                 mon_e.name, prdata, irq_o, mon_e.data, mon_e.irq);
                    end
                end
            end
            if (stim_done) begin
                while (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: read never observed, expected prdata=0x%08h",
                             mon_e.name, mon_e.data);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Watchdog so that a stuck run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin
        stim_done = 1'b0;
        presetn   = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        irq_i     = '0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        $display("[TB] reset values");
        checkOutput("reset_status", A_STATUS, 32'h0, 1'b0);
        checkOutput("reset_pend",   A_PEND,   32'h0, 1'b0);
        checkOutput("reset_mask",   A_MASK,   32'h0, 1'b0);
        checkOutput("claim_idle",   A_CLAIM,  32'h0, 1'b0);

        $display("[TB] edge, claim and status");
        applyStimulus(A_MASK, 32'hF, 1'b1);
        checkOutput("mask_rb", A_MASK, 32'hF, 1'b0);
        irq_i = 4'b0100;
        checkOutput("edge_pend",        A_PEND,   32'h4, 1'b0);
        irq_i = '0;
        checkOutput("armed_status",     A_STATUS, 32'h1, 1'b1);
        checkOutput("claim_read",       A_CLAIM,  32'h3, 1'b1);
        checkOutput("pend_after_claim", A_PEND,   32'h0, 1'b0);
        checkOutput("service_status",   A_STATUS, 32'h0302, 1'b0);
        checkOutput("claim_service",    A_CLAIM,  32'h0, 1'b0);

        $display("[TB] complete handling");
        applyStimulus(A_CLAIM, 32'h2, 1'b1);
        checkOutput("bad_complete_status", A_STATUS, 32'h0302, 1'b0);
        applyStimulus(A_CLAIM, 32'h3, 1'b1);
        checkOutput("complete_status", A_STATUS, 32'h0, 1'b0);
        applyStimulus(A_STATUS, 32'hFFFF_FFFF, 1'b1);
        checkOutput("status_write_ignored", A_STATUS, 32'h0, 1'b0);

        $display("[TB] masked source");
        applyStimulus(A_MASK, 32'h0, 1'b1);
        pulseIrq(4'b0010);
        checkOutput("masked_pend",   A_PEND,   32'h2, 1'b0);
        checkOutput("masked_status", A_STATUS, 32'h0, 1'b0);
        applyStimulus(A_MASK, 32'h2, 1'b1);
        checkOutput("unmask_status", A_STATUS, 32'h1, 1'b1);
        applyStimulus(A_PEND, 32'h2, 1'b1);
        checkOutput("w1c_status", A_STATUS, 32'h0, 1'b0);
        checkOutput("w1c_pend",   A_PEND,   32'h0, 1'b0);

        $display("[TB] set beats clear");
        pulseIrq(4'b0001);
        checkOutput("pend0_set", A_PEND, 32'h1, 1'b0);
        fork
            applyStimulus(A_PEND, 32'h1, 1'b1);
            begin
                @(posedge pclk); #1;
                irq_i = 4'b0001;
            end
        join
        checkOutput("set_wins_pend", A_PEND, 32'h1, 1'b0);
        irq_i = '0;
        applyStimulus(A_PEND, 32'h1, 1'b1);
        checkOutput("w1c_pend0", A_PEND, 32'h0, 1'b0);

        $display("[TB] arbitration order");
        applyStimulus(A_MASK, 32'hF, 1'b1);
        pulseIrq(4'b0001);
        checkOutput("warm_claim", A_CLAIM, 32'h1, 1'b1);
        applyStimulus(A_CLAIM, 32'h1, 1'b1);
        pulseIrq(4'b0101);
        checkOutput("arb_pend",   A_PEND,  32'h5, 1'b1);
        checkOutput("arb_claim1", A_CLAIM, FIRST_CLAIM, 1'b1);
        applyStimulus(A_CLAIM, FIRST_CLAIM, 1'b1);
        checkOutput("arb_claim2", A_CLAIM, SECOND_CLAIM, 1'b1);
        applyStimulus(A_CLAIM, SECOND_CLAIM, 1'b1);
        checkOutput("arb_pend_done",   A_PEND,   32'h0, 1'b0);
        checkOutput("arb_status_done", A_STATUS, 32'h0, 1'b0);

        $display("[TB] reset during service");
        pulseIrq(4'b0100);
        checkOutput("pre_reset_claim",  A_CLAIM,  32'h3, 1'b1);
        checkOutput("pre_reset_status", A_STATUS, 32'h0302, 1'b0);
        irq_i   = 4'b0001;
        presetn = 1'b0;
        checkOutput("in_reset_status", A_STATUS, 32'h0, 1'b0);
        checkOutput("in_reset_mask",   A_MASK,   32'h0, 1'b0);
        checkOutput("in_reset_pend",   A_PEND,   32'h0, 1'b0);
        presetn = 1'b1;
        checkOutput("held_pend",   A_PEND,   32'h1, 1'b0);
        checkOutput("held_status", A_STATUS, 32'h0, 1'b0);
        irq_i = '0;

        @(posedge pclk); #1;
        stim_done = 1'b1;
    end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_NUM, default 4, giving the number of interrupt sources (2 per timer, range 1..31).
REQ-002 The block SHALL have port pclk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port presetn, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port psel, input, 1, APB select.
REQ-005 The block SHALL have port penable, input, 1, APB enable (access phase).
REQ-006 The block SHALL have port pwrite, input, 1, APB write when high.
REQ-007 The block SHALL have port paddr, input, 32, APB address; only bits [3:2] are decoded.
REQ-008 The block SHALL have port pwdata, input, 32, APB write data.
REQ-009 The block SHALL have port prdata, output, 32, APB read data; 0 outside a read access phase.
REQ-010 The block SHALL have port pready, output, 1, tied to 1.
REQ-011 The block SHALL have port pslverr, output, 1, tied to 0.
REQ-012 The block SHALL have port irq_i, input, IRQ_NUM, level timer interrupts (overflow/compare per timer).
REQ-013 The block SHALL have port irq_o, output, 1, registered interrupt request to the CPU.

Function
REQ-014 The block SHALL decode paddr[3:2] as: 0 PEND, 1 MASK, 2 CLAIM, 3 STATUS. Access SHALL take effect only in the access phase (psel & penable).
REQ-015 PEND: irq_i SHALL be registered into irq_q every cycle. A rising edge (irq_i & ~irq_q) SHALL set the matching PEND bit on the next edge. PEND SHALL be write-1-to-clear. When a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-016 MASK: read/write, IRQ_NUM bits. A bit value of 1 enables the source. Masked sources SHALL still latch into PEND.
REQ-017 The FSM SHALL have three states: IDLE, ARMED, SERVICE.
REQ-018 FSM transitions:
- IDLE->ARMED when (PEND & MASK) != 0.
- ARMED->IDLE when (PEND & MASK) becomes 0 through W1C or a MASK write.
- ARMED->SERVICE on a CLAIM read.
REQ-019 A CLAIM read in ARMED SHALL:
- return the winner id+1 in prdata[5:0];
- store the id as active_id;
- clear that PEND bit on the same edge as the state change.
REQ-020 A CLAIM read in IDLE or SERVICE SHALL return 0 and change no state.
REQ-021 SERVICE->IDLE SHALL occur on a CLAIM write with pwdata[5:0] == active_id+1. A non-matching write SHALL be ignored.
REQ-022 The block SHALL not arbitrate during SERVICE; new edges SHALL latch into PEND only.
REQ-023 irq_o SHALL be 1 exactly while the state register equals ARMED; it SHALL be a registered output with no combinational path from irq_i.
REQ-024 STATUS (read-only) SHALL return: [1:0] state (0 IDLE, 1 ARMED, 2 SERVICE); [13:8] active_id+1, 0 when not in SERVICE.
REQ-025 Winner selection without the macro SHALL be fixed priority: the lowest index of PEND & MASK.
REQ-026 Unused bits SHALL read as 0. Writes to STATUS SHALL be ignored.

Reset
REQ-027 On presetn low the block SHALL immediately force: PEND=0, MASK=0, irq_q=0, state=IDLE, active_id=0, last_grant=IRQ_NUM-1, irq_o=0.
REQ-028 A source held high through reset release SHALL register as a rising edge on the first clock edge after reset.
REQ-029 Reset asserted mid-SERVICE SHALL abandon the claim; no complete is required afterwards.

Configuration
REQ-030 Macro TIMER_IRQ_CTRL_RR_EN selects the arbitration policy:
- Defined: round-robin arbitration; the search starts at index last_grant+1 modulo IRQ_NUM, and last_grant updates on each claim.
- Undefined: fixed priority per REQ-025, and last_grant is not implemented.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- MASK=0xF; pulse irq_i[2] -> PEND=0x4 and irq_o=1 two cycles after the edge; CLAIM read returns 3; PEND=0; irq_o=0; STATUS=0x0302.
- In SERVICE, write CLAIM=2 -> ignored, STATUS unchanged; write CLAIM=3 -> STATUS=0x0000.
- MASK=0; pulse irq_i[1] -> PEND=0x2, irq_o=0; write MASK=0x2 -> irq_o=1; write PEND=0x2 -> irq_o=0, state IDLE.
- In the same cycle, W1C PEND bit 0 and a rising edge on irq_i[0] -> PEND[0]=1.
- PEND=0x5, MASK=0xF, two claim/complete rounds -> claims 1,3 with RR_EN off; with RR_EN on and last_grant=0 -> claims 3,1.
- Assert presetn low during SERVICE -> all registers 0, irq_o=0 immediately; irq_i[0] held high -> PEND=0x1 after release.
